// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU control and multiply/divide engine.
// Holds the aluCtrl codes, aluOp/funct codes, engine state encoding and decode helpers.
package alu_pkg;

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluNor  = 4'b1100;
  localparam logic [3:0] AluNone = 4'b1111;

  localparam logic [1:0] OpAdd   = 2'b00;
  localparam logic [1:0] OpSub   = 2'b01;
  localparam logic [1:0] OpRtype = 2'b10;
  localparam logic [1:0] OpOr    = 2'b11;

  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnSubu  = 6'b100011;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnNor   = 6'b100111;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMthi  = 6'b010001;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMtlo  = 6'b010011;
  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10
  } md_state_e;

  function automatic logic [3:0] decode_funct(input logic [5:0] f);
    logic [3:0] ctrl;
    ctrl = AluNone;
    case (f)
      FnAdd, FnAddu: ctrl = AluAdd;
      FnSub, FnSubu: ctrl = AluSub;
      FnAnd:         ctrl = AluAnd;
      FnOr:          ctrl = AluOr;
      FnNor:         ctrl = AluNor;
      FnSlt:         ctrl = AluSlt;
      default:       ctrl = AluNone;
    endcase
    return ctrl;
  endfunction

  // Functs that touch HI/LO or the engine and therefore must wait while it is busy.
  function automatic logic is_hilo_funct(input logic [5:0] f);
    return (f == FnMult) || (f == FnMultu) || (f == FnDiv) || (f == FnDivu) ||
           (f == FnMfhi) || (f == FnMflo) || (f == FnMthi) || (f == FnMtlo);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative one-bit-per-cycle engine: shift-add multiplier and restoring divider.
// Works on magnitudes during CALC; FIX applies the result signs and presents hi/lo with done.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              isDiv,
  input  logic              isSigned,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              done,
  output logic              busy
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic              div_q, div_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic              bzero_q, bzero_d;

  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   mul_sum, div_rs, div_diff;
  logic [2*DATA_W-1:0] prod;

  always_comb begin
    a_neg    = isSigned & a[DATA_W-1];
    b_neg    = isSigned & b[DATA_W-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    mul_sum  = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opb_q : '0)};
    div_rs   = {acc_q, lo_q[DATA_W-1]};
    div_diff = div_rs - {1'b0, opb_q};

    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    bzero_d  = bzero_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StCalc;
          cnt_d    = CNT_W'(DATA_W - 1);
          acc_d    = '0;
          div_d    = isDiv;
          lo_d     = isDiv ? a_mag : b_mag;
          opb_d    = isDiv ? b_mag : a_mag;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = isDiv ? a_neg : (a_neg ^ b_neg);
          bzero_d  = (b == '0);
        end
      end
      StCalc: begin
        if (div_q) begin
          // Restoring step; a zero divisor naturally yields all-ones quotient, remainder = dividend.
          if (!div_diff[DATA_W]) begin
            acc_d = div_diff[DATA_W-1:0];
            lo_d  = {lo_q[DATA_W-2:0], 1'b1};
          end else begin
            acc_d = div_rs[DATA_W-1:0];
            lo_d  = {lo_q[DATA_W-2:0], 1'b0};
          end
        end else begin
          acc_d = mul_sum[DATA_W:1];
          lo_d  = {mul_sum[0], lo_q[DATA_W-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = StFix;
        end
      end
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    prod = {acc_q, lo_q};
    if (neg_lo_q) begin
      prod = -prod;
    end
    if (div_q) begin
      hi = neg_hi_q ? -acc_q : acc_q;
      lo = bzero_q ? '1 : (neg_lo_q ? -lo_q : lo_q);
    end else begin
      hi = prod[2*DATA_W-1:DATA_W];
      lo = prod[DATA_W-1:0];
    end
    done = (state_q == StFix);
    busy = (state_q != StIdle);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      bzero_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      bzero_q  <= bzero_d;
    end
  end

endmodule

// File: rtl/alu_control_muldiv.sv
// EX-stage ALU control: aluOp/funct decode, HI/LO registers, mult/div engine and its stall.
// HI/LO-touching instructions are held while the engine is busy; others overlap freely.
module alu_control_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic              flush,
  input  logic [1:0]        aluOp,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [3:0]        aluCtrl,
  output logic              resultSel,
  output logic [DATA_W-1:0] mdOut,
  output logic              stall,
  output logic              busy
);

  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] md_hi, md_lo;
  logic              md_done, md_busy;
  logic              is_rtype, is_mfhi, is_mflo, is_mthi, is_mtlo, is_muldiv;
  logic              accept, md_start, md_is_div, md_is_signed;

  always_comb begin
    is_rtype     = (aluOp == OpRtype);
    is_mfhi      = is_rtype & (funct == FnMfhi);
    is_mflo      = is_rtype & (funct == FnMflo);
    is_mthi      = is_rtype & (funct == FnMthi);
    is_mtlo      = is_rtype & (funct == FnMtlo);
    is_muldiv    = is_rtype & ((funct == FnMult) || (funct == FnMultu) ||
                               (funct == FnDiv)  || (funct == FnDivu));
    md_is_div    = (funct == FnDiv) || (funct == FnDivu);
    md_is_signed = (funct == FnMult) || (funct == FnDiv);

    unique case (aluOp)
      OpAdd:   aluCtrl = AluAdd;
      OpSub:   aluCtrl = AluSub;
      OpOr:    aluCtrl = AluOr;
      default: aluCtrl = decode_funct(funct);
    endcase

    resultSel = is_mfhi | is_mflo;
    mdOut     = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);

    busy     = md_busy;
    stall    = valid & md_busy & is_rtype & is_hilo_funct(funct);
    accept   = valid & ~flush & ~stall;
    md_start = accept & is_muldiv;
  end

  muldiv_iter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_muldiv_iter (
    .clock    (clock),
    .reset    (reset),
    .start    (md_start),
    .isDiv    (md_is_div),
    .isSigned (md_is_signed),
    .a        (A),
    .b        (B),
    .hi       (md_hi),
    .lo       (md_lo),
    .done     (md_done),
    .busy     (md_busy)
  );

  // MTHI/MTLO can only be accepted while idle, so they never collide with a FIX commit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (md_done) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
    end else begin
      if (accept && is_mthi) begin
        hi_q <= A;
      end
      if (accept && is_mtlo) begin
        lo_q <= A;
      end
    end
  end

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Randomized self-checking bench for alu_control_muldiv against an arithmetic reference model.
// The model tracks HI/LO with plain 64-bit arithmetic and the engine latency as a cycle count.
module tb_alu_control_muldiv;

  localparam int W = 32;
  localparam logic [5:0] FMFHI = 6'b010000, FMTHI = 6'b010001, FMFLO = 6'b010010;
  localparam logic [5:0] FMTLO = 6'b010011, FMULT = 6'b011000, FMULTU = 6'b011001;
  localparam logic [5:0] FDIV = 6'b011010, FDIVU = 6'b011011;

  logic         clock, reset, valid, flush;
  logic [1:0]   aluOp;
  logic [5:0]   funct;
  logic [W-1:0] A, B;
  logic [3:0]   aluCtrl;
  logic         resultSel, stall, busy;
  logic [W-1:0] mdOut;

  int unsigned  n_vec, n_bad;
  logic [W-1:0] hi_m, lo_m;
  logic [5:0]   fn_tbl [16];

  alu_control_muldiv #(.DATA_W(W), .CNT_W(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .valid     (valid),
    .flush     (flush),
    .aluOp     (aluOp),
    .funct     (funct),
    .A         (A),
    .B         (B),
    .aluCtrl   (aluCtrl),
    .resultSel (resultSel),
    .mdOut     (mdOut),
    .stall     (stall),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
    case (op)
      2'b00: return 4'b0010;
      2'b01: return 4'b0110;
      2'b11: return 4'b0001;
      default: begin
        case (f)
          6'h20, 6'h21: return 4'b0010;
          6'h22, 6'h23: return 4'b0110;
          6'h24:        return 4'b0000;
          6'h25:        return 4'b0001;
          6'h27:        return 4'b1100;
          6'h2a:        return 4'b0111;
          default:      return 4'b1111;
        endcase
      end
    endcase
  endfunction

  task automatic ref_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      FMULT: begin
        p = sa * sb;
        hi_m = p[63:32]; lo_m = p[31:0];
      end
      FMULTU: begin
        p = {32'b0, a} * {32'b0, b};
        hi_m = p[63:32]; lo_m = p[31:0];
      end
      FDIV: begin
        if (b == 0) begin
          lo_m = '1; hi_m = a;
        end else begin
          q = sa / sb; r = sa % sb;
          lo_m = q[31:0]; hi_m = r[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          lo_m = '1; hi_m = a;
        end else begin
          lo_m = a / b; hi_m = a % b;
        end
      end
    endcase
  endtask

  task automatic drive(input logic v, input logic fl, input logic [1:0] op, input logic [5:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    valid = v; flush = fl; aluOp = op; funct = f; A = a; B = b;
    #1;
  endtask

  // Present MFLO until the stall clears, then check stall length, LO and HI.
  task automatic wait_read(input string tag, input int exp_cycles);
    int cyc;
    drive(1'b1, 1'b0, 2'b10, FMFLO, '0, '0);
    cyc = 0;
    while (stall && cyc < 100) begin
      cyc++;
      @(negedge clock);
      #1;
    end
    check_eq({tag, "_stall_cycles"}, 64'(cyc), 64'(exp_cycles));
    check_eq({tag, "_lo"}, mdOut, lo_m);
    check_eq({tag, "_rsel"}, resultSel, 1'b1);
    drive(1'b1, 1'b0, 2'b10, FMFHI, '0, '0);
    check_eq({tag, "_hi"}, mdOut, hi_m);
    check_eq({tag, "_busy_after"}, busy, 1'b0);
  endtask

  task automatic run_md(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    drive(1'b1, 1'b0, 2'b10, f, a, b);
    check_eq({tag, "_start_stall"}, stall, 1'b0);
    ref_md(f, a, b);
    wait_read(tag, 33);
  endtask

  initial begin
    logic [1:0] op;
    logic [5:0] f;
    logic [W-1:0] a, b;
    n_vec = 0; n_bad = 0;
    hi_m = '0; lo_m = '0;
    fn_tbl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a,
               FMFHI, FMTHI, FMFLO, FMTLO, FMULT, FMULTU, FDIV, FDIVU};
    reset = 1'b0; valid = 1'b0; flush = 1'b0; aluOp = 2'b00; funct = '0; A = '0; B = '0;
    @(negedge clock);
    @(negedge clock);
    check_eq("rst_busy", busy, 1'b0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b10, FMFHI, '0, '0);
    check_eq("rst_hi", mdOut, '0);
    drive(1'b0, 1'b0, 2'b10, FMFLO, '0, '0);
    check_eq("rst_lo", mdOut, '0);

    drive(1'b0, 1'b0, 2'b10, 6'b100010, '0, '0); check_eq("dec_sub", aluCtrl, 4'b0110);
    drive(1'b0, 1'b0, 2'b10, 6'b101010, '0, '0); check_eq("dec_slt", aluCtrl, 4'b0111);
    drive(1'b0, 1'b0, 2'b00, 6'b101010, '0, '0); check_eq("dec_lw", aluCtrl, 4'b0010);
    drive(1'b0, 1'b0, 2'b10, 6'b111111, '0, '0); check_eq("dec_bad", aluCtrl, 4'b1111);

    run_md("mult_m3x5", FMULT, 32'hFFFF_FFFD, 32'd5);
    run_md("divu_100_7", FDIVU, 32'd100, 32'd7);
    run_md("div_m7_2", FDIV, 32'hFFFF_FFF9, 32'd2);
    run_md("div_by0", FDIV, 32'h0000_1234, 32'd0);

    for (int i = 0; i < 10; i++) begin
      f = fn_tbl[12 + $urandom_range(0, 3)];
      a = $urandom;
      b = (i % 4 == 3) ? '0 : ((i % 2 == 0) ? W'($urandom_range(1, 300)) : W'($urandom));
      run_md("rand_md", f, a, b);
    end

    // Random decode and HI/LO read-mux sweep with valid low so nothing is accepted.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      f = (i % 5 == 4) ? 6'($urandom) : fn_tbl[$urandom_range(0, 15)];
      drive(1'b0, 1'b0, op, f, $urandom, $urandom);
      check_eq("rand_ctrl", aluCtrl, ref_ctrl(op, f));
      check_eq("rand_rsel", resultSel, (op == 2'b10) && (f == FMFHI || f == FMFLO));
      check_eq("rand_mdout", mdOut,
               (op != 2'b10) ? '0 : (f == FMFHI) ? hi_m : (f == FMFLO) ? lo_m : '0);
    end

    a = $urandom; b = $urandom;
    drive(1'b1, 1'b0, 2'b10, FMTHI, a, '0); hi_m = a;
    drive(1'b1, 1'b0, 2'b10, FMTLO, b, '0); lo_m = b;
    drive(1'b1, 1'b0, 2'b10, FMFHI, '0, '0); check_eq("mthi", mdOut, hi_m);
    drive(1'b1, 1'b0, 2'b10, FMFLO, '0, '0); check_eq("mtlo", mdOut, lo_m);

    drive(1'b1, 1'b1, 2'b10, FMULT, 32'd9, 32'd9);
    drive(1'b0, 1'b0, 2'b00, 6'h00, '0, '0);
    check_eq("flush_busy", busy, 1'b0);
    drive(1'b1, 1'b0, 2'b10, FMFHI, '0, '0); check_eq("flush_hi", mdOut, hi_m);
    drive(1'b1, 1'b0, 2'b10, FMFLO, '0, '0); check_eq("flush_lo", mdOut, lo_m);

    a = $urandom; b = $urandom;
    drive(1'b1, 1'b0, 2'b10, FMULTU, a, b);
    ref_md(FMULTU, a, b);
    drive(1'b1, 1'b0, 2'b10, 6'h20, $urandom, $urandom);
    check_eq("ovl_stall", stall, 1'b0);
    check_eq("ovl_ctrl", aluCtrl, 4'b0010);
    check_eq("ovl_busy", busy, 1'b1);
    wait_read("ovl", 32);

    drive(1'b1, 1'b0, 2'b10, FMULT, $urandom, $urandom);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 2'b00, 6'h00, '0, '0);
    check_eq("mid_busy", busy, 1'b1);
    reset = 1'b0;
    drive(1'b1, 1'b0, 2'b10, FMFLO, '0, '0);
    reset = 1'b1;
    hi_m = '0; lo_m = '0;
    check_eq("rst2_busy", busy, 1'b0);
    check_eq("rst2_stall", stall, 1'b0);
    check_eq("rst2_lo", mdOut, '0);
    drive(1'b0, 1'b0, 2'b10, FMFHI, '0, '0);
    check_eq("rst2_hi", mdOut, '0);
    run_md("post_rst", FMULT, $urandom, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
